// File: rtl/carfield_region_map_ctrl_if.sv
// Register-port and lookup-port bundle for the runtime-reprogrammable region map.
interface carfield_region_map_ctrl_if #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned IdxWidth  = 8
);
  logic                 reg_req_i;
  logic                 reg_we_i;
  logic [10:0]          reg_addr_i;
  logic [31:0]          reg_wdata_i;
  logic                 reg_ready_o;
  logic [31:0]          reg_rdata_o;
  logic                 reg_error_o;
  logic                 lk_valid_i;
  logic                 lk_ready_o;
  logic [AddrWidth-1:0] lk_addr_i;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic                 res_hit_o;
  logic [IdxWidth-1:0]  res_idx_o;
  logic                 busy_o;

  modport master (
    output reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i, lk_valid_i, lk_addr_i, res_ready_i,
    input  reg_ready_o, reg_rdata_o, reg_error_o, lk_ready_o, res_valid_o, res_hit_o,
           res_idx_o, busy_o
  );

  modport slave (
    input  reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i, lk_valid_i, lk_addr_i, res_ready_i,
    output reg_ready_o, reg_rdata_o, reg_error_o, lk_ready_o, res_valid_o, res_hit_o,
           res_idx_o, busy_o
  );
endinterface

// File: rtl/carfield_region_map_ctrl.sv
// Shadow/active address-region decoder: software edits the shadow table, a commit
// drains the lookup pipeline and swaps shadow into active; a sticky lock freezes it.
module carfield_region_map_ctrl #(
  parameter int unsigned         NumRules   = 8,
  parameter int unsigned         AddrWidth  = 48,
  parameter int unsigned         IdxWidth   = 8,
  parameter logic [IdxWidth-1:0] DefaultIdx = '0,
  parameter logic [AddrWidth-1:0] RstStart [NumRules] = '{
    48'h0000_2000_0000, 48'h0000_7800_0000, 48'h0000_6000_0000, 48'h0000_5000_0000,
    48'h0001_0000_0000, '0, '0, '0},
  parameter logic [AddrWidth-1:0] RstEnd [NumRules] = '{
    48'h0000_2001_0000, 48'h0000_7840_0000, 48'h0000_6002_0000, 48'h0000_5080_0000,
    48'h0001_8000_0000, '0, '0, '0},
  parameter logic [IdxWidth-1:0] RstIdx [NumRules] = '{
    8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0},
  parameter logic RstEn [NumRules] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  carfield_region_map_ctrl_if.slave   bus
);
  localparam int unsigned HiW   = AddrWidth - 32;
  localparam int unsigned RuleW = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SWAP} state_e;

  state_e               r_state;
  logic                 r_busy;
  logic                 r_locked;
  logic                 r_res_valid;
  logic                 r_res_hit;
  logic [IdxWidth-1:0]  r_res_idx;

  logic [AddrWidth-1:0] r_sh_start  [NumRules];
  logic [AddrWidth-1:0] r_sh_end    [NumRules];
  logic                 r_sh_en     [NumRules];
  logic [IdxWidth-1:0]  r_sh_idx    [NumRules];
  logic [AddrWidth-1:0] r_act_start [NumRules];
  logic [AddrWidth-1:0] r_act_end   [NumRules];
  logic                 r_act_en    [NumRules];
  logic [IdxWidth-1:0]  r_act_idx   [NumRules];

  logic [RuleW-1:0]     w_rule;
  logic [4:0]           w_off;
  logic                 w_idle, w_is_rule, w_is_commit, w_is_status, w_is_lock, w_mapped;
  logic                 w_wr_ok, w_lk_ready, w_lk_fire, w_hit;
  logic [IdxWidth-1:0]  w_idx;
  logic [31:0]          w_rdata;

  // Register address decode
  assign w_rule      = bus.reg_addr_i[9:5];
  assign w_off       = bus.reg_addr_i[4:0];
  assign w_idle      = (r_state == ST_IDLE);
  assign w_is_rule   = !bus.reg_addr_i[10] && (32'(w_rule) < NumRules) &&
                       (w_off inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10});
  assign w_is_commit = (bus.reg_addr_i == 11'h400);
  assign w_is_status = (bus.reg_addr_i == 11'h404);
  assign w_is_lock   = (bus.reg_addr_i == 11'h408);
  assign w_mapped    = w_is_rule || w_is_commit || w_is_status || w_is_lock;
  assign w_wr_ok     = bus.reg_req_i && bus.reg_we_i && w_idle && w_mapped &&
                       !r_locked && !w_is_status;

  assign bus.reg_ready_o = bus.reg_req_i && (!bus.reg_we_i || w_idle);
  assign bus.reg_error_o = bus.reg_ready_o &&
                           (!w_mapped || (bus.reg_we_i && (r_locked || w_is_status)));
  assign bus.reg_rdata_o = w_rdata;

  always_comb begin
    w_rdata = '0;
    if (bus.reg_req_i && !bus.reg_we_i) begin
      if (w_is_status) begin
        w_rdata = {30'b0, r_locked, !w_idle};
      end else if (w_is_rule) begin
        for (int i = 0; i < int'(NumRules); i++) begin
          if (w_rule == RuleW'(i)) begin
            case (w_off)
              5'h00:   w_rdata = r_sh_start[i][31:0];
              5'h04:   w_rdata = 32'(r_sh_start[i][AddrWidth-1:32]);
              5'h08:   w_rdata = r_sh_end[i][31:0];
              5'h0C:   w_rdata = 32'(r_sh_end[i][AddrWidth-1:32]);
              5'h10:   w_rdata = 32'({r_sh_en[i], 8'(r_sh_idx[i])});
              default: w_rdata = '0;
            endcase
          end
        end
      end
    end
  end

  // Priority match: iterate downwards so the lowest matching rule wins
  always_comb begin
    w_hit = 1'b0;
    w_idx = DefaultIdx;
    for (int i = int'(NumRules) - 1; i >= 0; i--) begin
      if (r_act_en[i] && (bus.lk_addr_i >= r_act_start[i]) && (bus.lk_addr_i < r_act_end[i])) begin
        w_hit = 1'b1;
        w_idx = r_act_idx[i];
      end
    end
  end

  assign w_lk_ready      = (!r_res_valid || bus.res_ready_i) && w_idle;
  assign w_lk_fire       = bus.lk_valid_i && w_lk_ready;
  assign bus.lk_ready_o  = w_lk_ready;
  assign bus.res_valid_o = r_res_valid;
  assign bus.res_hit_o   = r_res_hit;
  assign bus.res_idx_o   = r_res_idx;
  assign bus.busy_o      = r_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_ok && w_is_commit && bus.reg_wdata_i[0]) begin
            r_state <= ST_DRAIN;
            r_busy  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!r_res_valid || bus.res_ready_i) r_state <= ST_SWAP;
        end
        ST_SWAP: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_wr_ok && w_is_lock && bus.reg_wdata_i[0]) r_locked <= 1'b1;
    end
  end

  // Rule tables: software edits land in shadow, SWAP copies shadow into active
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumRules); i++) begin
        r_sh_start[i]  <= RstStart[i];
        r_sh_end[i]    <= RstEnd[i];
        r_sh_en[i]     <= RstEn[i];
        r_sh_idx[i]    <= RstIdx[i];
        r_act_start[i] <= RstStart[i];
        r_act_end[i]   <= RstEnd[i];
        r_act_en[i]    <= RstEn[i];
        r_act_idx[i]   <= RstIdx[i];
      end
    end else begin
      for (int i = 0; i < int'(NumRules); i++) begin
        if (r_state == ST_SWAP) begin
          r_act_start[i] <= r_sh_start[i];
          r_act_end[i]   <= r_sh_end[i];
          r_act_en[i]    <= r_sh_en[i];
          r_act_idx[i]   <= r_sh_idx[i];
        end
        if (w_wr_ok && w_is_rule && (w_rule == RuleW'(i))) begin
          case (w_off)
            5'h00: r_sh_start[i][31:0]           <= bus.reg_wdata_i;
            5'h04: r_sh_start[i][AddrWidth-1:32] <= bus.reg_wdata_i[HiW-1:0];
            5'h08: r_sh_end[i][31:0]             <= bus.reg_wdata_i;
            5'h0C: r_sh_end[i][AddrWidth-1:32]   <= bus.reg_wdata_i[HiW-1:0];
            5'h10: begin
              r_sh_en[i]  <= bus.reg_wdata_i[8];
              r_sh_idx[i] <= bus.reg_wdata_i[IdxWidth-1:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_idx   <= '0;
    end else if (w_lk_fire) begin
      r_res_valid <= 1'b1;
      r_res_hit   <= w_hit;
      r_res_idx   <= w_idx;
    end else if (bus.res_ready_i) begin
      r_res_valid <= 1'b0;
    end
  end
endmodule
